// File: rtl/line_echo_fifo.sv
// Line-buffered echo FIFO: bytes from the receiver are queued and handed to the
// transmitter only once a complete line (terminator, length cap or full buffer) is held.
module line_echo_fifo #(
  parameter int DW         = 8,
  parameter int LGFLEN     = 8,
  parameter int MAXLINE    = 80,
  parameter int OPT_LFONLY = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_stb,
  input  logic [DW-1:0]     i_rx_data,
  output logic              o_tx_stb,
  output logic [DW-1:0]     o_tx_data,
  input  logic              i_tx_busy,
  output logic [LGFLEN:0]   o_fill,
  output logic [LGFLEN:0]   o_lines,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam int DEPTH = 1 << LGFLEN;
  localparam int LW    = $clog2(MAXLINE) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  logic [DW:0]     mem [DEPTH];
  logic [LGFLEN:0] head;
  logic [LGFLEN:0] tail;
  logic [LW-1:0]   llen;
  logic            tx_eol;
  state_t          state;

  logic wr;
  logic xfer;
  logic is_term;
  logic eol;

  assign o_fill  = head - tail;
  assign o_full  = (o_fill == (LGFLEN+1)'(DEPTH));
  assign o_empty = (o_fill == '0);

  assign wr   = i_rx_stb && !o_full;
  assign xfer = o_tx_stb && !i_tx_busy;

  always_comb begin
    is_term = (i_rx_data == DW'(8'h0a));
    if (OPT_LFONLY == 0 && i_rx_data == DW'(8'h0d))
      is_term = 1'b1;
  end

  // Closing the line on the write that fills the buffer guarantees the
  // transmitter can always drain, even when no terminator ever arrives.
  assign eol = is_term
            || (llen == LW'(MAXLINE - 1))
            || (o_fill == (LGFLEN+1)'(DEPTH - 1));

  always_ff @(posedge i_clk)
    if (wr)
      mem[head[LGFLEN-1:0]] <= {eol, i_rx_data};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      head       <= '0;
      llen       <= '0;
      o_lines    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr) begin
        head <= head + 1'b1;
        llen <= eol ? '0 : llen + 1'b1;
      end
      if (i_rx_stb && o_full)
        o_overflow <= 1'b1;
      case ({wr && eol, xfer && tx_eol})
        2'b10:   o_lines <= o_lines + 1'b1;
        2'b01:   o_lines <= o_lines - 1'b1;
        default: o_lines <= o_lines;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      tail      <= '0;
      o_tx_stb  <= 1'b0;
      o_tx_data <= '0;
      tx_eol    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (o_lines != '0) begin
            {tx_eol, o_tx_data} <= mem[tail[LGFLEN-1:0]];
            o_tx_stb            <= 1'b1;
            state               <= S_SEND;
          end
        end
        S_SEND: begin
          if (xfer) begin
            tail     <= tail + 1'b1;
            o_tx_stb <= 1'b0;
            state    <= S_GAP;
          end
        end
        S_GAP: begin
          // tail already points past the byte just sent
          if (tx_eol) begin
            state <= S_IDLE;
          end else begin
            {tx_eol, o_tx_data} <= mem[tail[LGFLEN-1:0]];
            o_tx_stb            <= 1'b1;
            state               <= S_SEND;
          end
        end
        default: begin
          state    <= S_IDLE;
          o_tx_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_echo_fifo.sv
// Bench for line_echo_fifo: a default instance and a small LF-only instance, checked
// against a queue-based model of whole-line release, plus directed corner sequences.
module tb_line_echo_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       rx_stb  = 1'b0;
  logic [7:0] rx_data = '0;
  logic       tx_busy = 1'b0;
  logic       sel     = 1'b0;

  logic       a_stb, a_full, a_empty, a_ovf;
  logic [7:0] a_data;
  logic [8:0] a_fill, a_lines;
  logic       b_stb, b_full, b_empty, b_ovf;
  logic [7:0] b_data;
  logic [4:0] b_fill, b_lines;

  line_echo_fifo dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_rx_stb(rx_stb && !sel), .i_rx_data(rx_data),
    .o_tx_stb(a_stb), .o_tx_data(a_data), .i_tx_busy(tx_busy || sel),
    .o_fill(a_fill), .o_lines(a_lines), .o_full(a_full), .o_empty(a_empty),
    .o_overflow(a_ovf)
  );

  line_echo_fifo #(.DW(8), .LGFLEN(4), .MAXLINE(16), .OPT_LFONLY(1)) dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_rx_stb(rx_stb && sel), .i_rx_data(rx_data),
    .o_tx_stb(b_stb), .o_tx_data(b_data), .i_tx_busy(tx_busy || !sel),
    .o_fill(b_fill), .o_lines(b_lines), .o_full(b_full), .o_empty(b_empty),
    .o_overflow(b_ovf)
  );

  logic       obs_stb, obs_full, obs_empty, obs_ovf;
  logic [7:0] obs_data;
  logic [8:0] obs_fill, obs_lines;

  always_comb begin
    if (sel) begin
      obs_stb = b_stb;  obs_data = b_data; obs_fill = {4'b0, b_fill};
      obs_lines = {4'b0, b_lines}; obs_full = b_full; obs_empty = b_empty; obs_ovf = b_ovf;
    end else begin
      obs_stb = a_stb;  obs_data = a_data; obs_fill = a_fill;
      obs_lines = a_lines; obs_full = a_full; obs_empty = a_empty; obs_ovf = a_ovf;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, inst=%0d)", name, act, exp, $time, sel);
    end
  endfunction

  // Reference model: queue of {eol, byte}; lines are counted, not tracked by pointer.
  logic [8:0] mq[$];
  int  m_lines, m_llen, m_depth, m_max, xfers;
  bit  m_lfonly, m_ovf, prev_xf;

  function automatic void model_clear();
    mq.delete();
    m_lines  = 0;
    m_llen   = 0;
    m_ovf    = 1'b0;
    prev_xf  = 1'b0;
    m_depth  = sel ? 16 : 256;
    m_max    = sel ? 16 : 80;
    m_lfonly = sel;
  endfunction

  task automatic step(input bit s, input logic [7:0] d, input bit busy);
    bit xf, wr, term, e;
    int sz;
    logic [8:0] front;
    rx_stb = s; rx_data = d; tx_busy = busy;
    #1;
    if (prev_xf) chk("gap_after_xfer", obs_stb, 0);
    if (obs_stb) begin
      chk("stb_has_line_data", mq.size() != 0, 1);
      if (mq.size() != 0) begin
        front = mq[0];
        chk("tx_data", obs_data, front[7:0]);
      end
    end
    xf = obs_stb && !busy;
    sz = mq.size();
    wr = s && (sz < m_depth);
    if (s && !wr) m_ovf = 1'b1;
    if (xf && sz > 0) begin
      front = mq.pop_front();
      if (front[8]) m_lines--;
      xfers++;
    end
    if (wr) begin
      term = (d == 8'h0a) || (!m_lfonly && d == 8'h0d);
      e = term || (m_llen + 1 == m_max) || (sz + 1 == m_depth);
      mq.push_back({e, d});
      if (e) begin m_lines++; m_llen = 0; end
      else m_llen++;
    end
    prev_xf = xf;
    @(posedge clk);
    @(negedge clk);
    chk("fill", obs_fill, mq.size());
    chk("lines", obs_lines, m_lines);
    chk("full", obs_full, mq.size() == m_depth);
    chk("empty", obs_empty, mq.size() == 0);
    chk("overflow", obs_ovf, m_ovf);
  endtask

  task automatic drain(input int extra);
    int n = 0;
    while ((m_lines != 0 || obs_stb) && n < 3000) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("drain_within_budget", n < 3000, 1);
    repeat (extra) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_stb(input bit busy);
    int n = 0;
    while (!obs_stb && n < 10) begin
      step(1'b0, 8'h00, busy);
      n++;
    end
    chk("stb_rises_in_time", obs_stb, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_stb = 1'b0; tx_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  typedef struct {
    bit         s;
    logic [7:0] d;
    bit         busy;
    bit         e_stb;
    logic [7:0] e_data;
    int         e_fill;
    int         e_lines;
  } vec_t;

  vec_t tbl[10];
  string s1;

  initial begin
    tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1, 0};
    tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 2, 0};
    tbl[2] = '{1'b1, 8'h0a, 1'b0, 1'b0, 8'h00, 3, 1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 3, 1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2, 1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 2, 1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1, 1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h0a, 1, 1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0};

    sel = 1'b0;
    do_reset();
    chk("rst_stb", obs_stb, 0);
    chk("rst_data", obs_data, 0);
    chk("rst_fill", obs_fill, 0);
    chk("rst_lines", obs_lines, 0);
    chk("rst_empty", obs_empty, 1);
    chk("rst_full", obs_full, 0);
    chk("rst_ovf", obs_ovf, 0);

    // "AB\n" with exact per-cycle timing
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s, tbl[i].d, tbl[i].busy);
      chk("tbl_stb", obs_stb, tbl[i].e_stb);
      if (tbl[i].e_stb) chk("tbl_data", obs_data, tbl[i].e_data);
      chk("tbl_fill", obs_fill, tbl[i].e_fill);
      chk("tbl_lines", obs_lines, tbl[i].e_lines);
    end

    // 85 bytes without terminator: first 80 form a forced line
    xfers = 0;
    for (int i = 0; i < 85; i++) step(1'b1, 8'h71, 1'b0);
    drain(4);
    chk("long_xfers", xfers, 80);
    chk("long_fill", obs_fill, 5);
    chk("long_lines", obs_lines, 0);

    // "a\rb\n" on both terminator modes
    s1 = "a\rb\n";
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, s1[i], 1'b1);
    chk("cr_lf_lines", obs_lines, 2);
    xfers = 0;
    drain(4);
    chk("cr_lf_xfers", xfers, 4);

    sel = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) step(1'b1, s1[i], 1'b1);
    chk("lfonly_lines", obs_lines, 1);
    chk("lfonly_fill", obs_fill, 4);
    xfers = 0;
    drain(4);
    chk("lfonly_xfers", xfers, 4);

    // Fill the 16-entry instance with busy held, then drain
    for (int i = 0; i < 20; i++) step(1'b1, 8'h78, 1'b1);
    chk("full_flag", obs_full, 1);
    chk("full_lines", obs_lines, 1);
    chk("full_ovf", obs_ovf, 1);
    chk("full_fill", obs_fill, 16);
    xfers = 0;
    drain(4);
    chk("full_xfers", xfers, 16);

    // Busy held during SEND
    sel = 1'b0;
    model_clear();
    step(1'b1, 8'h5a, 1'b1);
    step(1'b1, 8'h0a, 1'b1);
    wait_stb(1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("hold_stb", obs_stb, 1);
      chk("hold_data", obs_data, 8'h5a);
    end
    xfers = 0;
    drain(4);
    chk("hold_xfers", xfers, 2);

    // Asynchronous reset with three lines queued and a byte on offer
    s1 = "1\n2\n3\n";
    for (int i = 0; i < 6; i++) step(1'b1, s1[i], 1'b1);
    wait_stb(1'b1);
    #2 rst = 1'b1;
    #1 chk("async_stb_drop", obs_stb, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("async_fill", obs_fill, 0);
    chk("async_lines", obs_lines, 0);
    chk("async_ovf", obs_ovf, 0);
    chk("async_empty", obs_empty, 1);
    sel = 1'b1;
    #1;
    chk("async_b_ovf", obs_ovf, 0);
    chk("async_b_fill", obs_fill, 0);

    // Randomised traffic against the model on both instances
    for (int k = 0; k < 2; k++) begin
      sel = (k == 1);
      do_reset();
      for (int i = 0; i < 1500; i++) begin
        int r;
        logic [7:0] d;
        r = $urandom_range(0, 9);
        d = (r == 0) ? 8'h0a : (r == 1) ? 8'h0d : 8'($urandom_range(32, 126));
        step($urandom_range(0, 1) == 1, d,
             (i < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      end
      drain(4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_echo_fifo.md
Name: line_echo_fifo

Overview:
- Parametrised line-buffered echo stage between the parallel-port receive and transmit interfaces (pport rx_stb/rx_data in, tx_stb/tx_data/tx_busy out).
- Buffers received bytes in a FIFO and releases them to the transmitter one complete line at a time.
- Successor to the single-line echo: configurable depth, width and line length; any number of complete lines may be queued; true full/empty detection; overflow reporting; no deadlock when the buffer fills with a partial line.

Parameters:
- DW, 8, data byte width in bits.
- LGFLEN, 8, log2 of FIFO depth (depth = 2^LGFLEN entries).
- MAXLINE, 80, bytes after which a line is force-closed; legal range 1 to 2^LGFLEN.
- OPT_LFONLY, 0, 0 = 0x0a or 0x0d terminates a line; 1 = only 0x0a terminates.

Ports:
- i_clk, input, 1, system clock.
- i_reset, input, 1, asynchronous active-high reset.
- i_rx_stb, input, 1, one-cycle strobe: i_rx_data valid.
- i_rx_data, input, DW, received byte.
- o_tx_stb, output, 1, transmit request; o_tx_data valid while high.
- o_tx_data, output, DW, byte to transmit.
- i_tx_busy, input, 1, transmitter busy; a transfer occurs when o_tx_stb && !i_tx_busy.
- o_fill, output, LGFLEN+1, entries currently held.
- o_lines, output, LGFLEN+1, complete lines held.
- o_full, output, 1, o_fill == 2^LGFLEN.
- o_empty, output, 1, o_fill == 0.
- o_overflow, output, 1, sticky: at least one byte dropped since reset.

Behaviour:
- Reset (async, immediate): head, tail, o_fill, o_lines, line-length counter, o_tx_stb, o_overflow and state all 0; o_tx_data 0; o_empty = 1, o_full = 0. No other clear mechanism.
- Storage: memory is 2^LGFLEN x (DW+1); bit DW is the end-of-line (EOL) marker. head and tail are LGFLEN+1 bits wide and wrap modulo 2^(LGFLEN+1); memory is addressed by the low LGFLEN bits.
- Write: on i_rx_stb && !o_full, store {eol, i_rx_data} at head and increment head.
- Drop: on i_rx_stb && o_full, discard the byte, set o_overflow, and leave head and the line counter unchanged.
- eol = 1 for an accepted byte when any of these hold:
  - it is a terminator per OPT_LFONLY;
  - the line-length counter == MAXLINE-1 (this byte completes MAXLINE bytes);
  - this write makes the FIFO full (prevents deadlock on a partial line).
- Line-length counter: on an accepted write, reset to 0 when eol = 1, otherwise increment. Width is clog2(MAXLINE)+1.
- o_lines: +1 on each accepted eol write; -1 when the transfer of an EOL byte occurs; unchanged if both happen in the same cycle.
- Transmit FSM:
  - IDLE: if o_lines != 0 (registered value), load o_tx_data/eol from mem[tail], set o_tx_stb, go to SEND.
  - SEND: hold o_tx_stb, o_tx_data and the eol bit stable until a transfer occurs. On transfer, increment tail and drop o_tx_stb for one cycle (GAP).
  - GAP: if the transferred byte had eol = 1, go to IDLE; otherwise load mem[tail] and re-assert o_tx_stb (back to SEND).
- Latency:
  - Terminator sampled at edge N: o_lines increments at edge N; o_tx_stb is high after edge N+1 with the first byte of that line.
  - Between bytes of one line: exactly one low cycle of o_tx_stb after each transfer.
- Simultaneous write and transfer in one cycle: both pointers advance; o_fill unchanged.
  - A write to the last free slot in the same cycle as a transfer is still accepted, because fullness is evaluated before the transfer.
- Lines queue back-to-back and are sent in order. The FSM passes through IDLE for one cycle between lines.
- Empty-line case: a line consisting of a terminator alone is transmitted as that single byte.
- o_fill = head - tail (LGFLEN+1 bits). o_full and o_empty are derived from o_fill.
- Reset asserted mid-line or mid-transfer: o_tx_stb falls asynchronously; all queued and partial data is discarded.

Test Plan:
- Defaults, send "AB\n" with i_tx_busy = 0: o_lines 0→1 on the \n edge, then o_tx_stb pulses 'A','B',0x0a with one low cycle between bytes; afterwards o_lines = 0 and o_empty = 1.
- Send 85 non-terminator bytes: the 80th byte is force-closed as EOL and exactly 80 bytes are transmitted; 5 bytes remain with o_fill = 5 and o_lines = 0.
- LGFLEN = 4, MAXLINE = 16, i_tx_busy held high, send 20 bytes "x": o_full = 1 after 16 bytes, o_lines = 1, o_overflow = 1, o_fill = 16. Releasing busy drains exactly 16 bytes.
- Send "a\rb\n" with OPT_LFONLY = 0: two lines and o_lines = 2. With OPT_LFONLY = 1: one line of 4 bytes.
- Hold i_tx_busy high for 10 cycles during SEND: o_tx_data stays stable and tail does not move. On release, exactly one transfer is counted per byte.
- Assert i_reset asynchronously while o_tx_stb = 1 with 3 lines queued: o_tx_stb drops before the next clock edge; afterwards o_fill = 0, o_lines = 0, o_overflow = 0.
